// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one 11-bit-time frame per accepted LOAD at a
// captured baud divisor and reports completion through TXRDY and a one-cycle TX_INT.
module uart_tx_engine #(
    parameter int unsigned KW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          LOAD,
    input  logic [7:0]    OUT_PORT,
    input  logic          EIGHT,
    input  logic          PEN,
    input  logic          OHEL,
    input  logic [KW-1:0] K,
    output logic          TX,
    output logic          TXRDY,
    output logic          TX_INT
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0]    LastBit = 4'd10;
    localparam logic [KW-1:0] KOne    = KW'(1);

    state_e        state_q, state_d;
    logic [10:0]   shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [KW-1:0] baud_cnt_q, baud_cnt_d;
    logic [KW-1:0] kc_q, kc_d;
    logic          tx_int_q, tx_int_d;

    logic          parity;
    logic          b8;
    logic          b9;
    logic          btu;
    logic          last_btu;

    // State register; reset drops any frame in progress on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            kc_q       <= KOne;
            tx_int_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            kc_q       <= kc_d;
            tx_int_q   <= tx_int_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (LOAD) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (last_btu) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: frame build on accept, baud timing and shifting while busy.
    always_comb begin
        parity   = (EIGHT ? ^OUT_PORT : ^OUT_PORT[6:0]) ^ OHEL;
        b8       = EIGHT ? OUT_PORT[7] : (PEN ? parity : 1'b1);
        b9       = (EIGHT & PEN) ? parity : 1'b1;
        btu      = (state_q == StBusy) && (baud_cnt_q == (kc_q - KOne));
        last_btu = btu && (bit_cnt_q == LastBit);

        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        kc_d       = kc_q;
        tx_int_d   = 1'b0;

        if (state_q == StIdle) begin
            if (LOAD) begin
                shift_d    = {1'b1, b9, b8, OUT_PORT[6:0], 1'b0};
                bit_cnt_d  = '0;
                baud_cnt_d = '0;
                kc_d       = (K == '0) ? KOne : K;
            end
        end else if (btu) begin
            shift_d    = {1'b1, shift_q[10:1]};
            baud_cnt_d = '0;
            if (last_btu) begin
                bit_cnt_d = '0;
                tx_int_d  = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q + KOne;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        TX     = shift_q[0];
        TXRDY  = (state_q == StIdle);
        TX_INT = tx_int_q;
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a per-clock expected TX stream is queued when a
// frame is loaded and popped as the serial line is sampled.
module tb_uart_tx_engine;

    localparam int unsigned KW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [7:0]    out_port;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic [KW-1:0] k;
    logic          tx;
    logic          txrdy;
    logic          tx_int;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          exp_q[$];

    uart_tx_engine #(
        .KW(KW)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .LOAD    (load),
        .OUT_PORT(out_port),
        .EIGHT   (eight),
        .PEN     (pen),
        .OHEL    (ohel),
        .K       (k),
        .TX      (tx),
        .TXRDY   (txrdy),
        .TX_INT  (tx_int)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        logic par;
        logic s8;
        logic s9;
        par = (e ? ^d : ^d[6:0]) ^ o;
        s8  = e ? d[7] : (p ? par : 1'b1);
        s9  = (e && p) ? par : 1'b1;
        return {1'b1, s9, s8, d[6:0], 1'b0};
    endfunction

    task automatic push_frame(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic [KW-1:0] kk);
        logic [10:0] fr;
        int          kc;
        fr = model_frame(d, e, p, o);
        kc = (kk == '0) ? 1 : int'(kk);
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < kc; j++) begin
                exp_q.push_back(fr[i]);
            end
        end
    endtask

    task automatic drive_load(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic [KW-1:0] kk);
        @(posedge clk);
        #1;
        out_port = d;
        eight    = e;
        pen      = p;
        ohel     = o;
        k        = kk;
        load     = 1'b1;
        push_frame(d, e, p, o, kk);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic check_bits(input string tag, input int n);
        bit e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_eq({tag, "_qnonempty"}, exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq({tag, "_tx"}, tx, e);
            end
            check_eq({tag, "_txrdy"}, txrdy, 1'b0);
            check_eq({tag, "_txint"}, tx_int, 1'b0);
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check_eq({tag, "_rise_rdy"}, txrdy, 1'b1);
        check_eq({tag, "_rise_int"}, tx_int, 1'b1);
        check_eq({tag, "_rise_tx"}, tx, 1'b1);
        @(negedge clk);
        check_eq({tag, "_post_int"}, tx_int, 1'b0);
        check_eq({tag, "_post_rdy"}, txrdy, 1'b1);
        check_eq({tag, "_post_tx"}, tx, 1'b1);
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_eq({tag, "_tx"}, tx, 1'b1);
            check_eq({tag, "_txrdy"}, txrdy, 1'b1);
            check_eq({tag, "_txint"}, tx_int, 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        out_port = 8'h00;
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;
        k        = KW'(4);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("rst_idle", 10);

        // Reset held together with LOAD must not start a frame.
        @(posedge clk);
        #1;
        reset    = 1'b1;
        load     = 1'b1;
        out_port = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        check_idle("rst_load", 6);

        drive_load(8'hA5, 1'b1, 1'b0, 1'b0, KW'(4));
        check_bits("8n1", 44);
        check_done("8n1");

        drive_load(8'h41, 1'b0, 1'b1, 1'b0, KW'(3));
        check_bits("7e", 33);
        check_done("7e");

        drive_load(8'h03, 1'b1, 1'b1, 1'b1, KW'(2));
        check_bits("8o", 22);
        check_done("8o");

        drive_load(8'h55, 1'b1, 1'b0, 1'b0, KW'(0));
        check_bits("k0", 11);
        check_done("k0");

        // LOAD mid-frame with new data and divisor is ignored.
        drive_load(8'hA5, 1'b1, 1'b0, 1'b0, KW'(4));
        check_bits("busy", 17);
        load     = 1'b1;
        out_port = 8'h00;
        k        = KW'(9);
        @(posedge clk);
        #1;
        load = 1'b0;
        check_bits("busy", 27);
        check_done("busy");

        // LOAD on the TXRDY-rise edge is ignored; still high one edge later it is accepted.
        drive_load(8'hA5, 1'b1, 1'b0, 1'b0, KW'(4));
        check_bits("b2b1", 44);
        load     = 1'b1;
        out_port = 8'h5A;
        k        = KW'(2);
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;
        push_frame(8'h5A, 1'b1, 1'b0, 1'b0, KW'(2));
        @(negedge clk);
        check_eq("b2b_rise_rdy", txrdy, 1'b1);
        check_eq("b2b_rise_int", tx_int, 1'b1);
        check_eq("b2b_rise_tx", tx, 1'b1);
        @(posedge clk);
        #1;
        load = 1'b0;
        check_bits("b2b2", 22);
        check_done("b2b2");

        // Reset during bit 5 aborts the frame without an interrupt.
        drive_load(8'hA5, 1'b1, 1'b0, 1'b0, KW'(4));
        check_bits("abort", 21);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_tx", tx, 1'b1);
        check_eq("abort_txrdy", txrdy, 1'b1);
        check_eq("abort_txint", tx_int, 1'b0);
        exp_q.delete();
        reset = 1'b0;
        check_idle("abort_idle", 6);

        drive_load(8'hFF, 1'b1, 1'b0, 1'b0, KW'(3));
        check_bits("after", 33);
        check_done("after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
